// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path: opcodes, ALU
// control codes, controller states and instruction-register field positions.
package cpu_pkg;

  localparam int INSTR_W_DEF = 12;
  localparam int PC_W_DEF    = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_BEQ  = 4'h6,
    OP_LDI  = 4'h7,
    OP_JMP  = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;

  localparam logic [2:0] ALU_IDLE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;
  localparam logic [2:0] ALU_CMP  = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } ctrl_state_e;

  localparam int IR_OPC_LSB = 8;
  localparam int IR_RD_LSB  = 6;
  localparam int IR_RS_LSB  = 4;
  localparam int IR_RT_LSB  = 0;
  localparam int IR_IMM_LSB = 0;

endpackage

// File: rtl/cpu_instr_decoder.sv
// Purely combinational instruction decode: turns the latched IR into ALU
// control, register-file addresses and instruction-class flags.
module cpu_instr_decoder
  import cpu_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic [INSTR_W-1:0] i_ir,
  output logic [2:0]         o_alu_ctrl,
  output logic [1:0]         o_raddr_a,
  output logic [1:0]         o_raddr_b,
  output logic [1:0]         o_waddr,
  output logic               o_wsel,
  output logic               o_writes_rf,
  output logic               o_is_beq,
  output logic               o_is_jmp,
  output logic               o_is_halt,
  output logic               o_illegal,
  output logic [3:0]         o_imm
);

  logic [3:0] w_opc;

  assign w_opc = i_ir[IR_OPC_LSB +: 4];
  assign o_imm = i_ir[IR_IMM_LSB +: 4];

  // Opcode decode; BEQ compares rs against rd, so port B is redirected.
  always_comb begin
    o_alu_ctrl  = ALU_IDLE;
    o_raddr_a   = i_ir[IR_RS_LSB +: 2];
    o_raddr_b   = i_ir[IR_RT_LSB +: 2];
    o_waddr     = i_ir[IR_RD_LSB +: 2];
    o_wsel      = 1'b0;
    o_writes_rf = 1'b0;
    o_is_beq    = 1'b0;
    o_is_jmp    = 1'b0;
    o_is_halt   = 1'b0;
    o_illegal   = 1'b0;
    case (w_opc)
      OP_NOP: begin
        o_alu_ctrl = ALU_IDLE;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        o_alu_ctrl  = w_opc[2:0];
        o_writes_rf = 1'b1;
      end
      OP_BEQ: begin
        o_alu_ctrl = ALU_CMP;
        o_raddr_b  = i_ir[IR_RD_LSB +: 2];
        o_is_beq   = 1'b1;
      end
      OP_LDI: begin
        o_writes_rf = 1'b1;
        o_wsel      = 1'b1;
      end
      OP_JMP: begin
        o_is_jmp = 1'b1;
      end
      OP_HALT: begin
        o_is_halt = 1'b1;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle controller: FETCH/DECODE/EXEC/WB sequencing, IR and PC
// ownership, and datapath control decoded from registered state and IR.
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               instr_req,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic [2:0]         alu_ctrl,
  input  logic               alu_zero,
  output logic [1:0]         rf_raddr_a,
  output logic [1:0]         rf_raddr_b,
  output logic [1:0]         rf_waddr,
  output logic               rf_we,
  output logic               rf_wsel,
  output logic [3:0]         imm,
  output logic               busy,
  output logic               halted,
  output logic               illegal_op
);

  ctrl_state_e        r_state;
  ctrl_state_e        w_next;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic               r_taken;

  logic [2:0] w_alu_ctrl;
  logic [1:0] w_raddr_a;
  logic [1:0] w_raddr_b;
  logic [1:0] w_waddr;
  logic       w_wsel;
  logic       w_writes_rf;
  logic       w_is_beq;
  logic       w_is_jmp;
  logic       w_is_halt;
  logic       w_illegal;
  logic [3:0] w_imm;

  cpu_instr_decoder #(.INSTR_W(INSTR_W)) u_dec (
    .i_ir        (r_ir),
    .o_alu_ctrl  (w_alu_ctrl),
    .o_raddr_a   (w_raddr_a),
    .o_raddr_b   (w_raddr_b),
    .o_waddr     (w_waddr),
    .o_wsel      (w_wsel),
    .o_writes_rf (w_writes_rf),
    .o_is_beq    (w_is_beq),
    .o_is_jmp    (w_is_jmp),
    .o_is_halt   (w_is_halt),
    .o_illegal   (w_illegal),
    .o_imm       (w_imm)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; HALT only leaves through reset.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_FETCH; else w_next = ST_IDLE;
      ST_FETCH:  if (instr_valid) w_next = ST_DECODE; else w_next = ST_FETCH;
      ST_DECODE: w_next = ST_EXEC;
      ST_EXEC:   w_next = ST_WB;
      ST_WB:     if (w_is_halt) w_next = ST_HALT; else w_next = ST_FETCH;
      ST_HALT:   w_next = ST_HALT;
      default:   w_next = ST_IDLE;
    endcase
  end

  // IR capture, branch outcome and PC update. Gating alu_zero with the BEQ
  // flag keeps an undriven compare result out of r_taken for other opcodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir    <= {INSTR_W{1'b0}};
      r_pc    <= {PC_W{1'b0}};
      r_taken <= 1'b0;
    end else begin
      if (r_state == ST_FETCH && instr_valid) begin
        r_ir <= instr;
      end
      if (r_state == ST_EXEC) begin
        r_taken <= w_is_beq & alu_zero;
      end
      if (r_state == ST_WB && !w_is_halt) begin
        if (w_is_jmp || (w_is_beq && r_taken)) begin
          r_pc <= PC_W'(w_imm);
        end else begin
          r_pc <= r_pc + PC_W'(1);
        end
      end
    end
  end

  // Datapath controls decoded from the registered state and IR.
  always_comb begin
    instr_req  = 1'b0;
    alu_ctrl   = ALU_IDLE;
    rf_raddr_a = 2'b00;
    rf_raddr_b = 2'b00;
    rf_waddr   = 2'b00;
    rf_we      = 1'b0;
    rf_wsel    = 1'b0;
    illegal_op = 1'b0;
    case (r_state)
      ST_FETCH: begin
        instr_req = 1'b1;
      end
      ST_DECODE: begin
        rf_raddr_a = w_raddr_a;
        rf_raddr_b = w_raddr_b;
      end
      ST_EXEC: begin
        rf_raddr_a = w_raddr_a;
        rf_raddr_b = w_raddr_b;
        alu_ctrl   = w_alu_ctrl;
      end
      ST_WB: begin
        rf_raddr_a = w_raddr_a;
        rf_raddr_b = w_raddr_b;
        if (w_is_beq) alu_ctrl = ALU_IDLE; else alu_ctrl = w_alu_ctrl;
        rf_we      = w_writes_rf;
        if (w_writes_rf) rf_waddr = w_waddr; else rf_waddr = 2'b00;
        rf_wsel    = w_writes_rf & w_wsel;
        illegal_op = w_illegal;
      end
      default: begin
        instr_req = 1'b0;
      end
    endcase
  end

  assign pc     = r_pc;
  assign imm    = r_ir[IR_IMM_LSB +: 4];
  assign busy   = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign halted = (r_state == ST_HALT);

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: a table of single-instruction vectors
// run back to back, plus hand sequences for reset, HALT and start handling.
module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        instr_valid = 1'b0;
  logic [11:0] instr = 12'h000;
  logic        alu_zero = 1'b0;
  logic        instr_req;
  logic [3:0]  pc;
  logic [2:0]  alu_ctrl;
  logic [1:0]  rf_raddr_a;
  logic [1:0]  rf_raddr_b;
  logic [1:0]  rf_waddr;
  logic        rf_we;
  logic        rf_wsel;
  logic [3:0]  imm;
  logic        busy;
  logic        halted;
  logic        illegal_op;

  int checks = 0;
  int errors = 0;

  cpu_control_fsm #(.PC_W(4), .INSTR_W(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .instr_req   (instr_req),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .alu_ctrl    (alu_ctrl),
    .alu_zero    (alu_zero),
    .rf_raddr_a  (rf_raddr_a),
    .rf_raddr_b  (rf_raddr_b),
    .rf_waddr    (rf_waddr),
    .rf_we       (rf_we),
    .rf_wsel     (rf_wsel),
    .imm         (imm),
    .busy        (busy),
    .halted      (halted),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] instr;
    int          dly;
    logic        zero;
    logic [2:0]  a_exec;
    logic [2:0]  a_wb;
    logic        we;
    logic [1:0]  waddr;
    logic        wsel;
    logic [1:0]  ra;
    logic [1:0]  rb;
    logic        ill;
    logic        halt;
    logic [3:0]  pc_next;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered at a falling edge with the DUT in FETCH; leaves one edge after WB.
  task automatic run_vec(input vec_t v);
    for (int k = 0; k < v.dly; k++) begin
      chk("req_wait", {15'd0, instr_req}, 16'd1);
      instr_valid = 1'b0;
      instr       = 12'hF00;
      @(negedge clk);
    end
    chk("req", {15'd0, instr_req}, 16'd1);
    instr_valid = 1'b1;
    instr       = v.instr;
    @(negedge clk);
    chk("dec_req", {15'd0, instr_req}, 16'd0);
    chk("dec_alu", {13'd0, alu_ctrl}, 16'd0);
    chk("dec_busy", {15'd0, busy}, 16'd1);
    instr = 12'hF00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("exec_alu", {13'd0, alu_ctrl}, {13'd0, v.a_exec});
    if (v.a_exec != 3'b000) begin
      chk("exec_ra", {14'd0, rf_raddr_a}, {14'd0, v.ra});
      chk("exec_rb", {14'd0, rf_raddr_b}, {14'd0, v.rb});
    end
    chk("exec_we", {15'd0, rf_we}, 16'd0);
    alu_zero    = v.zero;
    instr_valid = 1'b0;
    @(negedge clk);
    alu_zero = 1'bx;
    chk("wb_alu", {13'd0, alu_ctrl}, {13'd0, v.a_wb});
    chk("wb_we", {15'd0, rf_we}, {15'd0, v.we});
    if (v.we) begin
      chk("wb_waddr", {14'd0, rf_waddr}, {14'd0, v.waddr});
      chk("wb_wsel", {15'd0, rf_wsel}, {15'd0, v.wsel});
    end
    chk("wb_imm", {12'd0, imm}, {12'd0, v.instr[3:0]});
    chk("wb_ill", {15'd0, illegal_op}, {15'd0, v.ill});
    @(negedge clk);
    chk("next_pc", {12'd0, pc}, {12'd0, v.pc_next});
    chk("next_we", {15'd0, rf_we}, 16'd0);
    chk("next_ill", {15'd0, illegal_op}, 16'd0);
    chk("next_halted", {15'd0, halted}, {15'd0, v.halt});
    chk("next_req", {15'd0, instr_req}, {15'd0, !v.halt});
    chk("next_busy", {15'd0, busy}, {15'd0, !v.halt});
  endtask

  initial begin
    //          instr    dly zero  aexec   awb     we    wa    wsel  ra    rb    ill   halt  pc
    vecs[0]  = '{12'h161, 0, 1'bx, 3'd1, 3'd1, 1'b1, 2'd1, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0, 4'd1};
    vecs[1]  = '{12'h615, 0, 1'b1, 3'd6, 3'd0, 1'b0, 2'd0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 4'd5};
    vecs[2]  = '{12'h615, 0, 1'b0, 3'd6, 3'd0, 1'b0, 2'd0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 4'd6};
    vecs[3]  = '{12'h7C9, 0, 1'bx, 3'd0, 3'd0, 1'b1, 2'd3, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 4'd7};
    vecs[4]  = '{12'h80F, 0, 1'bx, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 4'd15};
    vecs[5]  = '{12'h2E7, 0, 1'bx, 3'd2, 3'd2, 1'b1, 2'd3, 1'b0, 2'd2, 2'd3, 1'b0, 1'b0, 4'd0};
    vecs[6]  = '{12'h352, 0, 1'bx, 3'd3, 3'd3, 1'b1, 2'd1, 1'b0, 2'd1, 2'd2, 1'b0, 1'b0, 4'd1};
    vecs[7]  = '{12'h4A3, 0, 1'bx, 3'd4, 3'd4, 1'b1, 2'd2, 1'b0, 2'd2, 2'd3, 1'b0, 1'b0, 4'd2};
    vecs[8]  = '{12'h500, 0, 1'bx, 3'd5, 3'd5, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 4'd3};
    vecs[9]  = '{12'hA55, 3, 1'bx, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 4'd4};
    vecs[10] = '{12'h0FF, 1, 1'bx, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 4'd5};
    vecs[11] = '{12'h61C, 0, 1'b1, 3'd6, 3'd0, 1'b0, 2'd0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 4'd12};
    vecs[12] = '{12'hF00, 0, 1'bx, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 4'd12};

    // Reset state.
    @(negedge clk);
    chk("rst_pc", {12'd0, pc}, 16'd0);
    chk("rst_alu", {13'd0, alu_ctrl}, 16'd0);
    chk("rst_req", {15'd0, instr_req}, 16'd0);
    chk("rst_we", {15'd0, rf_we}, 16'd0);
    chk("rst_imm", {12'd0, imm}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req", {15'd0, instr_req}, 16'd0);

    // Reset in the middle of an ADD's EXEC cycle clears everything at once.
    start = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    instr_valid = 1'b1;
    instr       = 12'h161;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("t1_exec_alu", {13'd0, alu_ctrl}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_alu", {13'd0, alu_ctrl}, 16'd0);
    chk("t1_rst_busy", {15'd0, busy}, 16'd0);
    chk("t1_rst_pc", {12'd0, pc}, 16'd0);
    chk("t1_rst_ra", {14'd0, rf_raddr_a}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t1_idle_busy", {15'd0, busy}, 16'd0);
    chk("t1_idle_we", {15'd0, rf_we}, 16'd0);
    chk("t1_idle_pc", {12'd0, pc}, 16'd0);

    // Instruction table, run back to back.
    alu_zero = 1'bx;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_req", {15'd0, instr_req}, 16'd1);
    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i]);
    end

    // HALT is terminal: start is ignored and pc holds.
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("halt_halted", {15'd0, halted}, 16'd1);
    chk("halt_busy", {15'd0, busy}, 16'd0);
    chk("halt_pc", {12'd0, pc}, 16'd12);
    chk("halt_req", {15'd0, instr_req}, 16'd0);

    // Reset recovers from HALT; then reset mid-WB kills the write pulse.
    rst_n = 1'b0;
    #1;
    chk("halt_rst", {15'd0, halted}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    instr_valid = 1'b1;
    instr       = 12'h7C9;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wb_rst_pre_we", {15'd0, rf_we}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("wb_rst_we", {15'd0, rf_we}, 16'd0);
    chk("wb_rst_waddr", {14'd0, rf_waddr}, 16'd0);
    chk("wb_rst_pc", {12'd0, pc}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
